pad_conv_unpack: RTL and testbench
==================================

Name: pad_conv_unpack

Overview:
- Unpacks a 3-pixel packed window word (pixel 0 in bits [7:0], pixel 1 in [15:8], pixel 2 in [23:16]) into a serial pixel stream.
- Each pixel is tagged with the 2-bit slot code the packing stage consumes; an optional all-zero pad beat (slot 3) follows each word.
- Sits between the convolution-window memory/readout and any stage that takes (slot, pixel) beats, including the packer on the opposite side of the link.
- Valid/ready handshakes on both sides; one registered output stage.

Parameters:
- PIX_W, 8, pixel width in bits.
- NPIX, 3, pixels per packed word. Fixed at 3 in this revision because the slot code is 2 bits.
- PAD_EN, 1, 1 = emit a pad beat (slot 3, pixel 0) after pixel 2 of every word; 0 = no pad beat.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active low.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block accepts in_word this cycle.
- in_word  input  NPIX*PIX_W  packed word, pixel k in bits [k*PIX_W +: PIX_W].
- out_valid  output  1  out_pix/out_slot/out_last are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_pix  output  PIX_W  pixel value; 0 on the pad beat.
- out_slot  output  2  0,1,2 = pixel index; 3 = pad/clear.
- out_last  output  1  high on the final beat of a word: the pad beat if PAD_EN=1, else slot 2.
- words_done  output  16  count of fully emitted words; wraps modulo 2^16.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following clear immediately, regardless of the clock:
  - state = IDLE; held word cleared.
  - out_valid=0, out_pix=0, out_slot=0, out_last=0, words_done=0.
  - in_ready=0 while rst_n is low. in_ready rises one cycle after rst_n deasserts.
- Reset mid-word: the partially emitted word is discarded. No further beats of that word appear after release.
- Handshakes:
  - Input transfer occurs on a rising edge with in_valid && in_ready.
  - Output transfer occurs on a rising edge with out_valid && out_ready.
- Output stability: once out_valid is high, out_valid, out_pix, out_slot and out_last hold stable until the transfer completes.
- Input side: in_word is sampled only on an input transfer. in_valid may drop without a transfer; no state change results.
- State machine (state advances only on an output transfer):
  - IDLE: out_valid=0, in_ready=1. On input transfer: latch the word, go to S0.
  - S0: beat = pixel 0, slot 0. On transfer go to S1.
  - S1: beat = pixel 1, slot 1. On transfer go to S2.
  - S2: beat = pixel 2, slot 2. On transfer go to PAD if PAD_EN=1, else word end.
  - PAD: beat = pix 0, slot 3, last=1. On transfer, word end.
- Word end:
  - words_done increments on the same edge.
  - If an input transfer also occurs on that edge, go directly to S0 with the new word: no bubble.
  - Otherwise go to IDLE.
- in_ready: high in IDLE, or in the final-beat state (PAD, or S2 when PAD_EN=0) when out_ready=1. Low otherwise.
  - in_ready depends combinationally on out_ready; there is no combinational path from in_valid to out_valid.
- Latency: word accepted at edge N, so slot 0 is presented with out_valid=1 in the cycle after edge N.
- Throughput: 4 cycles/word (PAD_EN=1) or 3 cycles/word (PAD_EN=0) with out_ready held high.
- Backpressure: with out_ready=0 the current beat is held indefinitely; no beat is lost or duplicated.
- Width: out_pix is a direct slice of the held word; no arithmetic is applied to pixels. words_done wraps from 0xFFFF to 0x0000 with no flag.

Decomposition:
- Shared package holds:
  - PIX_W default.
  - Slot codes SLOT_P0=2'd0, SLOT_P1=2'd1, SLOT_P2=2'd2, SLOT_PAD=2'd3, shared with the packer.
  - The FSM state encoding.
- No sub-module. The held-word register, FSM and counter are small enough to live in one module.

Test Plan:
- Single word 0x332211, PAD_EN=1, out_ready=1:
  - Beats (slot,pix) = (0,0x11), (1,0x22), (2,0x33), (3,0x00) on consecutive cycles.
  - out_last only on the 4th beat; words_done=1.
- Back-to-back words 0xCCBBAA then 0x030201, in_valid held high:
  - 8 consecutive beats, no bubble.
  - in_ready high only in IDLE and on the PAD cycles.
  - words_done=2.
- Backpressure: out_ready toggles 1,0,0,1,... while streaming 0x665544.
  - Each beat is held stable while out_ready=0.
  - Beat order is unchanged: 0x44, 0x55, 0x66, then pad.
- PAD_EN=0, word 0x9F8E7D:
  - Beats (0,0x7D), (1,0x8E), (2,0x9F), with out_last on slot 2.
  - 3-cycle throughput over 3 back-to-back words.
- Reset mid-word: rst_n pulsed low after the slot-1 beat of 0x302010.
  - All outputs go to 0 immediately, out_valid=0, words_done=0.
  - After release the next word 0x605040 starts at slot 0.
- Loopback into the packer (its reset driven as the inverse of rst_n):
  - Pack output equals each sent in_word after slots 0..2.
  - Pack output clears to 0 after the pad beat.

Source files
------------

// File: rtl/pad_conv_unpack_pkg.sv
// Shared definitions for the window-word unpacker and its packer counterpart.
// Slot codes are part of the link format and must match on both sides.
package pad_conv_unpack_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int NPIX_DEF  = 3;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_P0  = 2'd0;
  localparam slot_t SLOT_P1  = 2'd1;
  localparam slot_t SLOT_P2  = 2'd2;
  localparam slot_t SLOT_PAD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_PAD
  } state_e;

endpackage

// File: rtl/pad_conv_unpack_if.sv
// Word-in / beat-out handshake bundle for pad_conv_unpack.
// The slave side is the unpacker; the master side feeds words and sinks beats.
interface pad_conv_unpack_if #(
  parameter int PIX_W = 8,
  parameter int NPIX  = 3
);
  import pad_conv_unpack_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [NPIX*PIX_W-1:0] in_word;
  logic                  out_valid;
  logic                  out_ready;
  logic [PIX_W-1:0]      out_pix;
  slot_t                 out_slot;
  logic                  out_last;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_pix, out_slot, out_last
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_pix, out_slot, out_last
  );

endinterface

// File: rtl/pad_conv_unpack.sv
// Serialises a packed 3-pixel window word into (slot, pixel) beats, with an
// optional zero pad beat per word. Beat outputs come straight from flops.
module pad_conv_unpack
  import pad_conv_unpack_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int NPIX   = NPIX_DEF,
  parameter bit PAD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  pad_conv_unpack_if.slave    bus,
  output logic [15:0]         words_done
);

  localparam int WW = NPIX * PIX_W;

  state_e           state_q, state_d;
  logic [WW-1:0]    word_q, word_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  slot_t            slot_q, slot_d;
  logic             last_q, last_d;
  logic             en_q;

  logic final_st, out_xfer, in_xfer;

  // en_q keeps in_ready low until the first edge after reset release.
  assign final_st     = (state_q == ST_PAD) || ((state_q == ST_S2) && !PAD_EN);
  assign bus.in_ready = en_q && ((state_q == ST_IDLE) || (final_st && bus.out_ready));
  assign out_xfer     = vld_q && bus.out_ready;
  assign in_xfer      = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (in_xfer) begin
        word_d  = bus.in_word;
        state_d = ST_S0;
      end
      ST_S0: if (out_xfer) state_d = ST_S1;
      ST_S1: if (out_xfer) state_d = ST_S2;
      ST_S2, ST_PAD: if (out_xfer) begin
        if ((state_q == ST_S2) && PAD_EN) begin
          state_d = ST_PAD;
        end else begin
          // Word end: a word accepted on this edge starts without a bubble.
          cnt_d = cnt_q + 16'd1;
          if (in_xfer) begin
            word_d  = bus.in_word;
            state_d = ST_S0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Beat registers follow the next state so they only move on a transfer.
    vld_d  = 1'b1;
    pix_d  = '0;
    slot_d = SLOT_P0;
    last_d = 1'b0;
    case (state_d)
      ST_S0: pix_d = word_d[0 +: PIX_W];
      ST_S1: begin
        pix_d  = word_d[PIX_W +: PIX_W];
        slot_d = SLOT_P1;
      end
      ST_S2: begin
        pix_d  = word_d[2*PIX_W +: PIX_W];
        slot_d = SLOT_P2;
        last_d = !PAD_EN;
      end
      ST_PAD: begin
        slot_d = SLOT_PAD;
        last_d = 1'b1;
      end
      default: vld_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      pix_q   <= '0;
      slot_q  <= SLOT_P0;
      last_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      pix_q   <= pix_d;
      slot_q  <= slot_d;
      last_q  <= last_d;
      en_q    <= 1'b1;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_pix   = pix_q;
  assign bus.out_slot  = slot_q;
  assign bus.out_last  = last_q;
  assign words_done    = cnt_q;

endmodule

// File: tb/tb_pad_conv_unpack.sv
// Directed bench: one unpacker with pad beats, one without, and a behavioural
// packer on the padded stream to close the loop.
module tb_pad_conv_unpack;

  logic clk;
  logic rst_n;
  logic [15:0] wd_a, wd_b;
  logic [23:0] pack_q;
  logic        pk_rst;

  int n_chk;
  int n_fail;

  pad_conv_unpack_if #(.PIX_W(8), .NPIX(3)) ua ();
  pad_conv_unpack_if #(.PIX_W(8), .NPIX(3)) ub ();

  pad_conv_unpack #(.PIX_W(8), .NPIX(3), .PAD_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ua), .words_done(wd_a)
  );

  pad_conv_unpack #(.PIX_W(8), .NPIX(3), .PAD_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ub), .words_done(wd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packer: assembles slots 0..2 into a word, slot 3 clears it.
  assign pk_rst = ~rst_n;
  always @(posedge clk or posedge pk_rst) begin
    if (pk_rst) pack_q <= '0;
    else if (ua.out_valid && ua.out_ready) begin
      if (ua.out_slot == 2'd3) pack_q <= '0;
      else pack_q[ua.out_slot*8 +: 8] <= ua.out_pix;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input string tag, input logic v, input logic [1:0] s, input logic [7:0] p,
                      input logic l, input logic [1:0] es, input logic [7:0] ep, input logic el);
    chk({tag, ".valid"}, 32'(v), 32'd1);
    chk({tag, ".slot"},  32'(s), 32'(es));
    chk({tag, ".pix"},   32'(p), 32'(ep));
    chk({tag, ".last"},  32'(l), 32'(el));
  endtask

  task automatic beat_a(input string tag, input logic [1:0] es, input logic [7:0] ep, input logic el);
    beat(tag, ua.out_valid, ua.out_slot, ua.out_pix, ua.out_last, es, ep, el);
  endtask

  task automatic beat_b(input string tag, input logic [1:0] es, input logic [7:0] ep, input logic el);
    beat(tag, ub.out_valid, ub.out_slot, ub.out_pix, ub.out_last, es, ep, el);
  endtask

  logic [23:0] bw [3];
  logic [23:0] w;
  logic [7:0]  ep;
  int          k;
  int          n;
  logic        r;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    ua.in_valid = 1'b0; ua.in_word = '0; ua.out_ready = 1'b1;
    ub.in_valid = 1'b0; ub.in_word = '0; ub.out_ready = 1'b1;
    bw[0] = 24'h9F8E7D; bw[1] = 24'hA1B2C3; bw[2] = 24'h0F0E0D;

    // Reset state
    #1;
    chk("rst.valid", 32'(ua.out_valid), 0);
    chk("rst.pix",   32'(ua.out_pix), 0);
    chk("rst.slot",  32'(ua.out_slot), 0);
    chk("rst.last",  32'(ua.out_last), 0);
    chk("rst.wd",    32'(wd_a), 0);
    chk("rst.rdy",   32'(ua.in_ready), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel.rdy0", 32'(ua.in_ready), 0);
    @(negedge clk);
    chk("rel.rdy1", 32'(ua.in_ready), 1);

    // Single word with pad
    ua.in_valid = 1'b1; ua.in_word = 24'h332211;
    @(negedge clk); ua.in_valid = 1'b0;
    beat_a("t1b0", 2'd0, 8'h11, 1'b0);
    chk("t1.rdy0", 32'(ua.in_ready), 0);
    @(negedge clk); beat_a("t1b1", 2'd1, 8'h22, 1'b0);
    @(negedge clk); beat_a("t1b2", 2'd2, 8'h33, 1'b0);
    @(negedge clk); beat_a("t1b3", 2'd3, 8'h00, 1'b1);
    chk("t1.rdy_pad", 32'(ua.in_ready), 1);
    chk("t1.pack", 32'(pack_q), 32'h332211);
    @(negedge clk);
    chk("t1.idle", 32'(ua.out_valid), 0);
    chk("t1.wd", 32'(wd_a), 1);
    chk("t1.pack_clr", 32'(pack_q), 0);

    // Back-to-back words, in_valid held high
    chk("t2.rdy_idle", 32'(ua.in_ready), 1);
    ua.in_valid = 1'b1; ua.in_word = 24'hCCBBAA;
    @(negedge clk); beat_a("t2b0", 2'd0, 8'hAA, 1'b0);
    chk("t2.rdy0", 32'(ua.in_ready), 0);
    ua.in_word = 24'h030201;
    @(negedge clk); beat_a("t2b1", 2'd1, 8'hBB, 1'b0);
    chk("t2.rdy1", 32'(ua.in_ready), 0);
    @(negedge clk); beat_a("t2b2", 2'd2, 8'hCC, 1'b0);
    chk("t2.rdy2", 32'(ua.in_ready), 0);
    @(negedge clk); beat_a("t2b3", 2'd3, 8'h00, 1'b1);
    chk("t2.rdy3", 32'(ua.in_ready), 1);
    chk("t2.pack0", 32'(pack_q), 32'hCCBBAA);
    @(negedge clk); beat_a("t2b4", 2'd0, 8'h01, 1'b0);
    chk("t2.rdy4", 32'(ua.in_ready), 0);
    ua.in_valid = 1'b0;
    @(negedge clk); beat_a("t2b5", 2'd1, 8'h02, 1'b0);
    @(negedge clk); beat_a("t2b6", 2'd2, 8'h03, 1'b0);
    @(negedge clk); beat_a("t2b7", 2'd3, 8'h00, 1'b1);
    chk("t2.pack1", 32'(pack_q), 32'h030201);
    @(negedge clk);
    chk("t2.idle", 32'(ua.out_valid), 0);
    chk("t2.wd", 32'(wd_a), 3);  // cumulative: 1 earlier word + 2 here

    // Backpressure: out_ready 1,0,0,1,0,0,...
    w = 24'h665544;
    ua.in_valid = 1'b1; ua.in_word = w;
    @(negedge clk); ua.in_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 12 && k < 4; i++) begin
      ep = (k < 3) ? w[k*8 +: 8] : 8'h00;
      beat_a($sformatf("bp%0d", i), k[1:0], ep, (k == 3));
      if (k == 3) chk("bp.pack", 32'(pack_q), 32'h665544);
      r = (i % 3 == 0);
      ua.out_ready = r;
      #1 chk($sformatf("bp%0d.rdy", i), 32'(ua.in_ready), 32'((k == 3) && r));
      if (r) k++;
      @(negedge clk);
    end
    chk("bp.done", 32'(k), 4);
    ua.out_ready = 1'b1;
    chk("bp.idle", 32'(ua.out_valid), 0);
    chk("bp.wd", 32'(wd_a), 4);

    // No pad: 3 back-to-back words at 3 cycles/word
    ub.in_valid = 1'b1; ub.in_word = bw[0];
    for (int wi = 0; wi < 3; wi++) begin
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        w  = bw[wi];
        ep = w[s*8 +: 8];
        beat_b($sformatf("nb%0d_%0d", wi, s), 2'(s), ep, (s == 2));
        chk($sformatf("nb%0d_%0d.rdy", wi, s), 32'(ub.in_ready), 32'(s == 2));
        if (s == 2) begin
          if (wi < 2) ub.in_word = bw[wi+1];
          else ub.in_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("nb.idle", 32'(ub.out_valid), 0);
    chk("nb.wd", 32'(wd_b), 3);

    // Reset mid-word
    ua.in_valid = 1'b1; ua.in_word = 24'h302010;
    @(negedge clk); ua.in_valid = 1'b0;
    beat_a("rm0", 2'd0, 8'h10, 1'b0);
    @(negedge clk); beat_a("rm1", 2'd1, 8'h20, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rm.valid", 32'(ua.out_valid), 0);
    chk("rm.pix",   32'(ua.out_pix), 0);
    chk("rm.slot",  32'(ua.out_slot), 0);
    chk("rm.last",  32'(ua.out_last), 0);
    chk("rm.wd",    32'(wd_a), 0);
    chk("rm.wdb",   32'(wd_b), 0);
    chk("rm.rdy",   32'(ua.in_ready), 0);
    chk("rm.pack",  32'(pack_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ua.in_valid = 1'b1; ua.in_word = 24'h605040;
    #1 chk("rm.rdy_rel", 32'(ua.in_ready), 0);
    n = 0;
    while (!ua.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rm.wait", 32'(ua.out_valid), 1);
    ua.in_valid = 1'b0;
    beat_a("rn0", 2'd0, 8'h40, 1'b0);
    @(negedge clk); beat_a("rn1", 2'd1, 8'h50, 1'b0);
    @(negedge clk); beat_a("rn2", 2'd2, 8'h60, 1'b0);
    @(negedge clk); beat_a("rn3", 2'd3, 8'h00, 1'b1);
    chk("rn.pack", 32'(pack_q), 32'h605040);
    @(negedge clk);
    chk("rn.idle", 32'(ua.out_valid), 0);
    chk("rn.wd", 32'(wd_a), 1);
    chk("rn.pack_clr", 32'(pack_q), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
